// File: rtl/nord10s_pkg.sv
// Shared types and constants for the shift/loop sequencer and its status-card linkage.
package nord10s_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StShift  = 2'd2,
    StFinish = 2'd3
  } shseq_state_t;

  // Status card shift counter width.
  localparam int unsigned SHC_W = 6;

  localparam int unsigned WDOG_MAX_DEF = 40;

endpackage

// File: rtl/shseq_cnt.sv
// Saturating stroke counter with synchronous clear, increment and limit compare.
module shseq_cnt #(
  parameter int unsigned CntW  = 7,
  parameter int unsigned Limit = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [CntW-1:0] cnt,
  output logic            at_limit
);

  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] LimitVal = CntW'(Limit);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LimitVal);

endmodule

// File: rtl/shift_seq.sv
// Shift/loop micro-op sequencer: WSHC load, SHCKL strokes until TERM, then one SKL strobe.
// Define SHSEQ_WDOG_EN to abort runaway shifts after WDOG_MAX strokes and flag ERR.
module shift_seq
  import nord10s_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEF,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SHSTART,
  input  logic             TERM,
  output logic             WSHC,
  output logic             SHCKL,
  output logic             SKL,
  output logic             HOLD,
  output logic             DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] SHN,
  output logic             ERR
);

  shseq_state_t state_q;
  logic         at_limit;
  logic         wdog_hit;
  logic         stroke;
  logic         accept;

  assign accept = (state_q == StIdle) && SHSTART;

`ifdef SHSEQ_WDOG_EN
  logic err_q;
  assign wdog_hit = (state_q == StShift) && !TERM && at_limit;
  assign ERR      = err_q;
`else
  logic wdog_unused;
  assign wdog_unused = at_limit;
  assign wdog_hit    = 1'b0;
  assign ERR         = 1'b0;
`endif

  // A shift stroke only counts in SHIFT; the LOAD-cycle SHCKL is the counter load.
  assign stroke = (state_q == StShift) && !TERM && !wdog_hit;

  shseq_cnt #(
    .CntW  (CNT_W),
    .Limit (WDOG_MAX)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .inc      (stroke),
    .cnt      (SHN),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
`ifdef SHSEQ_WDOG_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (SHSTART) begin
            state_q <= StLoad;
`ifdef SHSEQ_WDOG_EN
            err_q   <= 1'b0;
`endif
          end
        end
        StLoad: state_q <= StShift;
        StShift: begin
          if (TERM) begin
            state_q <= StFinish;
          end else if (wdog_hit) begin
            state_q <= StFinish;
`ifdef SHSEQ_WDOG_EN
            err_q   <= 1'b1;
`endif
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    WSHC  = (state_q == StLoad);
    SHCKL = (state_q == StLoad) || stroke;
    SKL   = (state_q == StFinish);
    DONE  = (state_q == StFinish);
    HOLD  = (state_q == StLoad) || (state_q == StShift);
    BUSY  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: per-cycle vector table plus long-run/watchdog sequences.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       term;
  logic       wshc, shckl, skl, hold, done, busy, err;
  logic [6:0] shn;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_seq dut (
    .clk     (clk),
    .rst     (rst),
    .SHSTART (start),
    .TERM    (term),
    .WSHC    (wshc),
    .SHCKL   (shckl),
    .SKL     (skl),
    .HOLD    (hold),
    .DONE    (done),
    .BUSY    (busy),
    .SHN     (shn),
    .ERR     (err)
  );

  typedef struct packed {
    logic       r, s, t;
    logic       w, c, k, h, d, b;
    logic [6:0] n;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, t, w, c, k, h, d, b, input logic [6:0] n);
    vec_t v;
    v.r = r; v.s = s; v.t = t;
    v.w = w; v.c = c; v.k = k; v.h = h; v.d = d; v.b = b;
    v.n = n;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs just after an edge, then sample on the falling edge.
  task automatic drive(input logic s, input logic t);
    start = s;
    term  = t;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; term = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 5 strokes
    add(0,0,0, 0,0,0,0,0,0, 7'd0);
    add(0,1,0, 0,0,0,0,0,0, 7'd0);
    add(0,0,0, 1,1,0,1,0,1, 7'd0);
    for (int i = 0; i < 5; i++) add(0,0,0, 0,1,0,1,0,1, 7'(i));
    add(0,0,1, 0,0,0,1,0,1, 7'd5);
    add(0,1,0, 0,0,1,0,1,1, 7'd5);  // start in FINISH is dropped
    add(0,0,0, 0,0,0,0,0,0, 7'd5);
    // zero count
    add(0,1,1, 0,0,0,0,0,0, 7'd5);
    add(0,0,1, 1,1,0,1,0,1, 7'd0);
    add(0,0,1, 0,0,0,1,0,1, 7'd0);
    add(0,0,1, 0,0,1,0,1,1, 7'd0);
    // SHSTART held high: one op per 4 cycles
    for (int op = 0; op < 2; op++) begin
      add(0,1,1, 0,0,0,0,0,0, 7'd0);
      add(0,1,1, 1,1,0,1,0,1, 7'd0);
      add(0,1,1, 0,0,0,1,0,1, 7'd0);
      add(0,1,1, 0,0,1,0,1,1, 7'd0);
    end
    add(0,0,0, 0,0,0,0,0,0, 7'd0);
    // reset after 3 strokes
    add(0,1,0, 0,0,0,0,0,0, 7'd0);
    add(0,0,0, 1,1,0,1,0,1, 7'd0);
    for (int i = 0; i < 3; i++) add(0,0,0, 0,1,0,1,0,1, 7'(i));
    add(1,0,0, 0,1,0,1,0,1, 7'd3);
    add(0,0,0, 0,0,0,0,0,0, 7'd0);
    add(0,0,1, 0,0,0,0,0,0, 7'd0);
    add(0,0,0, 0,0,0,0,0,0, 7'd0);

    foreach (vq[i]) begin
      rst = vq[i].r;
      drive(vq[i].s, vq[i].t);
      check($sformatf("vec%0d {wshc,shckl,skl,hold,done,busy,err,shn}", i),
            32'({wshc, shckl, skl, hold, done, busy, err, shn}),
            32'({vq[i].w, vq[i].c, vq[i].k, vq[i].h, vq[i].d, vq[i].b, 1'b0, vq[i].n}));
      adv();
    end
    rst = 1'b0;

`ifdef SHSEQ_WDOG_EN
    // TERM stuck low: 40 strokes then forced FINISH with ERR
    drive(1, 0); adv();
    drive(0, 0); check("wd_load_wshc", 32'(wshc), 32'd1); adv();
    for (int i = 0; i < 40; i++) begin
      drive(0, 0);
      check($sformatf("wd_shckl%0d", i), 32'(shckl), 32'd1);
      check($sformatf("wd_shn%0d", i), 32'(shn), 32'(i));
      adv();
    end
    drive(0, 0);
    check("wd_cut_shckl", 32'(shckl), 32'd0);
    check("wd_cut_hold", 32'(hold), 32'd1);
    check("wd_cut_shn", 32'(shn), 32'd40);
    adv();
    drive(0, 0);
    check("wd_fin_skl_done_err", 32'({skl, done, err}), 32'b111);
    adv();
    drive(1, 0);
    check("wd_idle_err_sticky", 32'({busy, err}), 32'b01);
    adv();
    drive(0, 1);
    check("wd_next_load_err_clr", 32'({wshc, err}), 32'b10);
    adv();
    drive(0, 1); adv();
    drive(0, 0);
    check("wd_next_done", 32'({done, err, shn}), 32'({1'b1, 1'b0, 7'd0}));
    adv();
`else
    // TERM stuck low for 200 cycles: continuous strokes, SHN saturates
    drive(1, 0); adv();
    drive(0, 0); check("long_load_wshc", 32'(wshc), 32'd1); adv();
    for (int i = 0; i < 200; i++) begin
      drive(0, 0);
      check($sformatf("long_shckl%0d", i), 32'(shckl), 32'd1);
      check($sformatf("long_shn%0d", i), 32'(shn), 32'((i < 127) ? i : 127));
      check($sformatf("long_err%0d", i), 32'(err), 32'd0);
      adv();
    end
    drive(0, 1);
    check("long_term_shckl", 32'({shckl, hold, shn}), 32'({1'b0, 1'b1, 7'd127}));
    adv();
    drive(0, 0);
    check("long_done", 32'({skl, done, err, shn}), 32'({1'b1, 1'b1, 1'b0, 7'd127}));
    adv();
    drive(0, 0);
    check("long_idle", 32'({busy, done, shn}), 32'({1'b0, 1'b0, 7'd127}));
    adv();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
